dmem_ctrl: RTL and testbench

Parametrised single-port data memory with a valid/ready request channel and a registered response channel, serving RV32 loads and stores (byte, halfword, word, signed/unsigned). Generalises the fixed-size RAM: configurable depth, explicit illegal/out-of-range faulting, and optional split handling of misaligned accesses. Sits between the MEM pipeline stage and the word-wide storage array.

---
 rtl/dmem_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RV32 byte/half/word data memory with a valid/ready request channel and a registered response.
// Define DMEM_MISALIGN_EN to split misaligned H/W accesses across two words via a SPLIT state.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          load,
  input  logic          store,
  input  logic [2:0]    access,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   data_in,
  output logic          rsp_valid,
  output logic          rsp_fault,
  output logic [31:0]   data_out
);
  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] acc);
    case (acc)
      3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
      3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
      3'b100:  extend = {24'd0, raw[7:0]};
      3'b101:  extend = {16'd0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  logic [2:0]    size;
  logic [1:0]    off;
  logic [3:0]    be_full;
  logic [3:0]    be_first;
  logic [AW:0]   last_byte;
  logic [IW-1:0] widx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_first;
  logic [31:0]   wd_first;
  logic          illegal;
  logic          misal;
  logic          in_range;
  logic          fault;
  logic          accept;

  logic          we;
  logic [IW-1:0] wa;
  logic [3:0]    wbe;
  logic [31:0]   wd;
  logic          rsp_valid_d;
  logic          rsp_fault_d;
  logic [31:0]   data_out_d;

  // Request decode: lane placement, legality and range of the last addressed byte
  always_comb begin
    off = addr[1:0];
    case (access[1:0])
      2'b00:   begin size = 3'd1; be_full = 4'b0001; end
      2'b01:   begin size = 3'd2; be_full = 4'b0011; end
      default: begin size = 3'd4; be_full = 4'b1111; end
    endcase
    illegal   = (access == 3'b011) || (access[2:1] == 2'b11) || (access[2] && store);
    misal     = ((access[1:0] == 2'b01) && addr[0]) || ((access[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    last_byte = {1'b0, addr} + (AW+1)'(size) - (AW+1)'(1);
    in_range  = (last_byte >> 2) < (AW+1)'(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_EN
    fault     = illegal || !in_range;
`else
    fault     = illegal || !in_range || misal;
`endif
    accept    = req_valid && req_ready && (load != store);
    widx      = addr[IW+1:2];
    rd_word   = mem[widx];
    rd_first  = rd_word >> {off, 3'b000};
    wd_first  = data_in << {off, 3'b000};
    be_first  = be_full << off;
  end

`ifdef DMEM_MISALIGN_EN
  typedef enum logic {IDLE, SPLIT} state_t;

  function automatic logic [31:0] bytes_mask(input logic [2:0] n);
    case (n)
      3'd0:    bytes_mask = 32'h0000_0000;
      3'd1:    bytes_mask = 32'h0000_00FF;
      3'd2:    bytes_mask = 32'h0000_FFFF;
      3'd3:    bytes_mask = 32'h00FF_FFFF;
      default: bytes_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [3:0] lanes_mask(input logic [2:0] n);
    case (n)
      3'd0:    lanes_mask = 4'b0000;
      3'd1:    lanes_mask = 4'b0001;
      3'd2:    lanes_mask = 4'b0011;
      3'd3:    lanes_mask = 4'b0111;
      default: lanes_mask = 4'b1111;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic          ready_q;
  logic          split_ld;
  logic [2:0]    room, n1, rem;
  logic [IW-1:0] nidx_q;
  logic [2:0]    n1_q, rem_q;
  logic [31:0]   part_q, sdata_q, rd_next;
  logic [2:0]    acc_q;
  logic          st_q;

  always_comb begin
    room    = 3'd4 - {1'b0, off};
    n1      = (size < room) ? size : room;
    rem     = size - n1;
    rd_next = mem[nidx_q];
  end

  assign req_ready = ready_q;
`else
  assign req_ready = 1'b1;
`endif

  // Next response, memory write port and (with split support) next state
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    data_out_d  = '0;
    we          = 1'b0;
    wa          = widx;
    wbe         = be_first;
    wd          = wd_first;
`ifdef DMEM_MISALIGN_EN
    state_d     = state_q;
    split_ld    = 1'b0;
    if (state_q == SPLIT) begin
      we          = st_q;
      wa          = nidx_q;
      wbe         = lanes_mask(rem_q);
      wd          = sdata_q;
      rsp_valid_d = 1'b1;
      data_out_d  = st_q ? '0 :
                    extend(part_q | ((rd_next & bytes_mask(rem_q)) << {n1_q, 3'b000}), acc_q);
      state_d     = IDLE;
    end else if (accept) begin
`else
    if (accept) begin
`endif
      if (fault) begin
        rsp_valid_d = 1'b1;
        rsp_fault_d = 1'b1;
      end
`ifdef DMEM_MISALIGN_EN
      else if (misal) begin
        we       = store;
        split_ld = 1'b1;
        state_d  = SPLIT;
      end
`endif
      else begin
        we          = store;
        rsp_valid_d = 1'b1;
        data_out_d  = store ? '0 : extend(rd_first, access);
      end
    end
  end

  // Response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      data_out  <= '0;
    end else begin
      rsp_valid <= rsp_valid_d;
      rsp_fault <= rsp_fault_d;
      data_out  <= data_out_d;
    end
  end

`ifdef DMEM_MISALIGN_EN
  // FSM state and the half of a split request still to be performed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      nidx_q  <= '0;
      n1_q    <= '0;
      rem_q   <= '0;
      part_q  <= '0;
      sdata_q <= '0;
      acc_q   <= '0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      if (split_ld) begin
        nidx_q  <= widx + IW'(1);
        n1_q    <= n1;
        rem_q   <= rem;
        part_q  <= rd_first & bytes_mask(n1);
        sdata_q <= data_in >> {n1, 3'b000};
        acc_q   <= access;
        st_q    <= store;
      end
    end
  end
`endif

  // Storage array is deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[wa][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed plus randomized checks of dmem_ctrl against a byte-array reference model.
module tb_dmem_ctrl;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
`ifdef DMEM_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          req_valid = 1'b0;
  logic          load      = 1'b0;
  logic          store     = 1'b0;
  logic [2:0]    access    = 3'b000;
  logic [AW-1:0] addr      = '0;
  logic [31:0]   data_in   = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_fault;
  logic [31:0]   data_out;

  int checks   = 0;
  int failures = 0;
  logic [7:0] mdl [DW*4];

  dmem_ctrl #(.DEPTH_WORDS(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .load      (load),
    .store     (store),
    .access    (access),
    .addr      (addr),
    .data_in   (data_in),
    .rsp_valid (rsp_valid),
    .rsp_fault (rsp_fault),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-level reference: little-endian bytes, sign handled arithmetically
  task automatic model(input logic ld, input logic st, input logic [2:0] acc,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic flt, output logic [31:0] dout, output int lat);
    int n;
    logic mis;
    longint v, last;
    n    = (acc[1:0] == 2'b00) ? 1 : (acc[1:0] == 2'b01) ? 2 : 4;
    mis  = (int'(a[1:0]) % n) != 0;
    last = longint'({32'd0, a}) + n - 1;
    flt  = (acc inside {3'b011, 3'b110, 3'b111}) || (acc[2] && st) ||
           (last >= longint'(DW*4)) || (mis && !MIS);
    lat  = (mis && !flt) ? 2 : 1;
    dout = '0;
    if (!flt) begin
      if (st) begin
        for (int i = 0; i < n; i++) mdl[int'(a) + i] = d[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mdl[int'(a) + i]) << (8*i);
        if (!acc[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
        dout = 32'(v);
      end
    end
    if (ld) begin end
  endtask

  task automatic xact(input string tag, input logic ld, input logic st, input logic [2:0] acc,
                      input logic [31:0] a, input logic [31:0] d);
    logic flt;
    logic [31:0] dout;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; load = ld; store = st; access = acc; addr = a; data_in = d;
    @(negedge clk);
    req_valid = 1'b0; load = 1'b0; store = 1'b0;
    if (ld == st) begin
      chk({tag, ":ignored0"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk({tag, ":ignored1"}, 32'(rsp_valid), 32'd0);
    end else begin
      model(ld, st, acc, a, d, flt, dout, lat);
      if (lat == 2) begin
        chk({tag, ":split_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ":split_norsp"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
      end
      chk({tag, ":valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ":fault"}, 32'(rsp_fault), 32'(flt));
      chk({tag, ":data"},  data_out, dout);
      chk({tag, ":ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    logic        r_ld, r_st;
    logic [2:0]  r_acc;
    logic [31:0] r_a, r_d, e0, e1;
    logic        f0, f1;
    int          r, l0, l1;

    // Outputs while reset is held
    #12;
    chk("rst:ready", 32'(req_ready), 32'd1);
    chk("rst:valid", 32'(rsp_valid), 32'd0);
    chk("rst:fault", 32'(rsp_fault), 32'd0);
    chk("rst:data",  data_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int w = 0; w < DW; w++) xact("fill", 1'b0, 1'b1, 3'b010, 32'(4*w), $urandom);
    xact("sw0", 1'b0, 1'b1, 3'b010, 32'd0, 32'h0011_2233);
    xact("sw4", 1'b0, 1'b1, 3'b010, 32'd4, 32'hAABB_CCDD);

    xact("lb7",  1'b1, 1'b0, 3'b000, 32'd7, 32'd0); chk("lb7:plan",  data_out, 32'hFFFF_FFAA);
    xact("lbu7", 1'b1, 1'b0, 3'b100, 32'd7, 32'd0); chk("lbu7:plan", data_out, 32'h0000_00AA);
    xact("lb1",  1'b1, 1'b0, 3'b000, 32'd1, 32'd0); chk("lb1:plan",  data_out, 32'h0000_0022);
    xact("lh6",  1'b1, 1'b0, 3'b001, 32'd6, 32'd0); chk("lh6:plan",  data_out, 32'hFFFF_AABB);
    xact("lhu2", 1'b1, 1'b0, 3'b101, 32'd2, 32'd0); chk("lhu2:plan", data_out, 32'h0000_0011);
    xact("lw4",  1'b1, 1'b0, 3'b010, 32'd4, 32'd0); chk("lw4:plan",  data_out, 32'hAABB_CCDD);

    xact("sh2", 1'b0, 1'b1, 3'b001, 32'd2, 32'h0000_CCDD);
    xact("sb5", 1'b0, 1'b1, 3'b000, 32'd5, 32'h0000_0077);
    xact("lw0p", 1'b1, 1'b0, 3'b010, 32'd0, 32'd0); chk("lw0p:plan", data_out, 32'hCCDD_2233);
    xact("lw4p", 1'b1, 1'b0, 3'b010, 32'd4, 32'd0); chk("lw4p:plan", data_out, 32'hAABB_77DD);

    xact("lw64", 1'b1, 1'b0, 3'b010, 32'd64, 32'd0);
    chk("lw64:plan_fault", 32'(rsp_fault), 32'd1);
    chk("lw64:plan_data", data_out, 32'd0);
    xact("sb_bu", 1'b0, 1'b1, 3'b100, 32'd0, 32'h0000_0099);
    chk("sb_bu:plan_fault", 32'(rsp_fault), 32'd1);
    xact("lw0u", 1'b1, 1'b0, 3'b010, 32'd0, 32'd0); chk("lw0u:plan", data_out, 32'hCCDD_2233);
    xact("both",    1'b1, 1'b1, 3'b010, 32'd0, 32'd0);
    xact("neither", 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);

    xact("sw0b", 1'b0, 1'b1, 3'b010, 32'd0, 32'h0011_2233);
    xact("sw4b", 1'b0, 1'b1, 3'b010, 32'd4, 32'hAABB_CCDD);
    xact("lw3", 1'b1, 1'b0, 3'b010, 32'd3, 32'd0);
`ifdef DMEM_MISALIGN_EN
    chk("lw3:plan", data_out, 32'hBBCC_DD00);
    xact("sw6", 1'b0, 1'b1, 3'b010, 32'd6, 32'h1122_3344);
    xact("lw4m", 1'b1, 1'b0, 3'b010, 32'd4, 32'd0); chk("lw4m:plan", data_out, 32'h3344_CCDD);
    xact("lw8m", 1'b1, 1'b0, 3'b010, 32'd8, 32'd0); chk("lw8m:plan_lo", 32'(data_out[15:0]), 32'h0000_1122);

    // Reset asserted during the SPLIT cycle of a misaligned store
    xact("rs_sw4", 1'b0, 1'b1, 3'b010, 32'd4, 32'hAABB_CCDD);
    @(negedge clk);
    req_valid = 1'b1; store = 1'b1; access = 3'b010; addr = 32'd6; data_in = 32'h5566_7788;
    @(posedge clk);
    #2;
    rst = 1'b0; req_valid = 1'b0; store = 1'b0;
    @(negedge clk);
    chk("rs:ready", 32'(req_ready), 32'd1);
    chk("rs:valid", 32'(rsp_valid), 32'd0);
    chk("rs:fault", 32'(rsp_fault), 32'd0);
    chk("rs:data",  data_out, 32'd0);
    @(negedge clk);
    chk("rs:valid_hold", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rs:valid_after", 32'(rsp_valid), 32'd0);
    mdl[6] = 8'h88;
    mdl[7] = 8'h77;
    xact("rs_lw4", 1'b1, 1'b0, 3'b010, 32'd4, 32'd0); chk("rs_lw4:plan", data_out, 32'h7788_CCDD);
    xact("rs_lw8", 1'b1, 1'b0, 3'b010, 32'd8, 32'd0); chk("rs_lw8:plan_lo", 32'(data_out[15:0]), 32'h0000_1122);
`else
    chk("lw3:plan_fault", 32'(rsp_fault), 32'd1);
    chk("lw3:plan_data", data_out, 32'd0);
`endif

    // Back-to-back aligned loads: one response per cycle
    model(1'b1, 1'b0, 3'b010, 32'd0, 32'd0, f0, e0, l0);
    model(1'b1, 1'b0, 3'b001, 32'd6, 32'd0, f1, e1, l1);
    @(negedge clk);
    req_valid = 1'b1; load = 1'b1; access = 3'b010; addr = 32'd0;
    @(negedge clk);
    access = 3'b001; addr = 32'd6;
    chk("b2b0:valid", 32'(rsp_valid), 32'd1);
    chk("b2b0:data", data_out, e0);
    @(negedge clk);
    req_valid = 1'b0; load = 1'b0;
    chk("b2b1:valid", 32'(rsp_valid), 32'd1);
    chk("b2b1:data", data_out, e1);
    @(negedge clk);
    chk("b2b:idle", 32'(rsp_valid), 32'd0);

    // Randomized mix, including illegal encodings, out-of-range and misaligned addresses
    for (int it = 0; it < 150; it++) begin
      r = int'($urandom_range(0, 9));
      r_ld = (r < 5);
      r_st = (r >= 5) && (r < 9);
      if (r == 9) begin
        r_ld = 1'($urandom_range(0, 1));
        r_st = r_ld;
      end
      r_acc = 3'($urandom_range(0, 7));
      r_a   = 32'($urandom_range(0, DW*4 + 5));
      r_d   = $urandom;
      xact("rnd", r_ld, r_st, r_acc, r_a, r_d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
